// File: rtl/control_pkg.sv
// Shared types and encodings for the multicycle control sequencer.
package control_pkg;

    localparam int unsigned MEM_WAIT_MAX_DEF = 15;
    localparam int unsigned CNT_W_DEF        = 32;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC,
        ALUWB,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        BRANCH,
        FAULT
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] REG_NORM = 2'b00;
    localparam logic [1:0] REG_BR   = 2'b01;
    localparam logic [1:0] REG_ST   = 2'b10;

endpackage

// File: rtl/control_wait_timer.sv
// Counts consecutive unanswered memory-request cycles; expired flags the cycle
// in which the wait limit is reached without a ready.
module control_wait_timer #(
    parameter int unsigned MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic ready,
    output logic expired
);

    localparam int unsigned W = $clog2(MAX + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (req && !ready) begin
            cnt <= cnt + W'(1);
        end else begin
            cnt <= '0;
        end
    end

    // This cycle would be the MAX-th unanswered one; a ready now takes priority.
    assign expired = req && !ready && (cnt == W'(MAX - 1));

endmodule

// File: rtl/control_multicycle_fsm.sv
// Multicycle control sequencer: fetch/decode/execute/memory/writeback with a
// waited memory handshake. Optional perf counters via PERF_CNT_EN.
module control_multicycle_fsm
    import control_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = MEM_WAIT_MAX_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       op,
    input  logic             funct5,
    input  logic             funct0,
    input  logic             cond_ok,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             adrsrc,
    output logic             irwrite,
    output logic             pcwrite,
    output logic             regw,
    output logic             memw,
    output logic             memtoreg,
    output logic             alusrc,
    output logic             branch,
    output logic             aluop,
    output logic [1:0]       immsrc,
    output logic [1:0]       regsrc,
    output logic             instr_done,
    output logic             fault
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    state_t state_q;
    state_t state_d;
    logic   funct5_q;
    logic   funct0_q;
    logic   expired;

    control_wait_timer #(
        .MAX (MEM_WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (mem_req),
        .ready   (mem_ready),
        .expired (expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction fields held from DECODE to retirement; the op class itself
    // is carried by the state path chosen in DECODE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct5_q <= 1'b0;
            funct0_q <= 1'b0;
        end else if (state_q == DECODE) begin
            funct5_q <= funct5;
            funct0_q <= funct0;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (mem_ready)    state_d = DECODE;
                else if (expired) state_d = FAULT;
            end
            DECODE: begin
                case (op)
                    OP_DP:  state_d = EXEC;
                    OP_MEM: state_d = MEMADR;
                    OP_BR:  state_d = BRANCH;
                    OP_ILL: state_d = FAULT;
                endcase
            end
            EXEC:   state_d = ALUWB;
            ALUWB:  state_d = FETCH;
            MEMADR: state_d = funct0_q ? MEMRD : MEMWR;
            MEMRD: begin
                if (mem_ready)    state_d = MEMWB;
                else if (expired) state_d = FAULT;
            end
            MEMWB:  state_d = FETCH;
            MEMWR: begin
                if (mem_ready)    state_d = FETCH;
                else if (expired) state_d = FAULT;
            end
            BRANCH: state_d = FETCH;
            FAULT:  state_d = FAULT;
            default: state_d = FAULT;
        endcase
    end

    // Moore output decode, forced to zero while reset is asserted
    always_comb begin
        mem_req    = 1'b0;
        adrsrc     = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        regw       = 1'b0;
        memw       = 1'b0;
        memtoreg   = 1'b0;
        alusrc     = 1'b0;
        branch     = 1'b0;
        aluop      = 1'b0;
        immsrc     = IMM_DP;
        regsrc     = REG_NORM;
        instr_done = 1'b0;
        fault      = 1'b0;
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    mem_req = 1'b1;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                EXEC: begin
                    alusrc = funct5_q;
                    immsrc = IMM_DP;
                    aluop  = 1'b1;
                end
                ALUWB: begin
                    regw       = 1'b1;
                    regsrc     = REG_NORM;
                    aluop      = 1'b1;
                    instr_done = 1'b1;
                end
                MEMADR: begin
                    alusrc = 1'b1;
                    immsrc = IMM_MEM;
                end
                MEMRD: begin
                    mem_req = 1'b1;
                    adrsrc  = 1'b1;
                end
                MEMWB: begin
                    regw       = 1'b1;
                    memtoreg   = 1'b1;
                    instr_done = 1'b1;
                end
                MEMWR: begin
                    mem_req    = 1'b1;
                    adrsrc     = 1'b1;
                    memw       = 1'b1;
                    regsrc     = REG_ST;
                    instr_done = mem_ready;
                end
                BRANCH: begin
                    branch     = 1'b1;
                    alusrc     = 1'b1;
                    immsrc     = IMM_BR;
                    regsrc     = REG_BR;
                    pcwrite    = cond_ok;
                    instr_done = 1'b1;
                end
                FAULT: begin
                    fault = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PERF_CNT_EN
    // Perf counters, frozen once the sequencer has faulted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt   <= '0;
            instr_cnt <= '0;
        end else if (state_q != FAULT) begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (instr_done) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_control_multicycle_fsm.sv
// Self-checking bench for control_multicycle_fsm: per-cycle expected control
// vectors are queued as stimulus is driven and compared at the falling edge.
module tb_control_multicycle_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] op = 2'b00;
    logic       funct5 = 1'b0;
    logic       funct0 = 1'b0;
    logic       cond_ok = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, adrsrc, irwrite, pcwrite, regw, memw, memtoreg;
    logic       alusrc, branch, aluop, instr_done, fault;
    logic [1:0] immsrc, regsrc;
`ifdef PERF_CNT_EN
    logic [31:0] cyc_cnt, instr_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    logic [15:0] exp_q[$];
    logic [15:0] outvec;

    localparam logic [15:0] MREQ   = 16'h8000;
    localparam logic [15:0] ADR    = 16'h4000;
    localparam logic [15:0] IRW    = 16'h2000;
    localparam logic [15:0] PCW    = 16'h1000;
    localparam logic [15:0] REGW   = 16'h0800;
    localparam logic [15:0] MEMW   = 16'h0400;
    localparam logic [15:0] M2R    = 16'h0200;
    localparam logic [15:0] ASRC   = 16'h0100;
    localparam logic [15:0] BR     = 16'h0080;
    localparam logic [15:0] AOP    = 16'h0040;
    localparam logic [15:0] IMM01  = 16'h0010;
    localparam logic [15:0] IMM10  = 16'h0020;
    localparam logic [15:0] RS01   = 16'h0004;
    localparam logic [15:0] RS10   = 16'h0008;
    localparam logic [15:0] DONE   = 16'h0002;
    localparam logic [15:0] FLT    = 16'h0001;
    localparam logic [15:0] V_FRDY = MREQ | IRW | PCW;
    localparam logic [15:0] V_BRN  = BR | ASRC | IMM10 | RS01 | DONE;
    localparam logic [15:0] V_WR   = MREQ | ADR | MEMW | RS10;

    assign outvec = {mem_req, adrsrc, irwrite, pcwrite, regw, memw, memtoreg,
                     alusrc, branch, aluop, immsrc, regsrc, instr_done, fault};

    always #5 clk = ~clk;

    control_multicycle_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct5     (funct5),
        .funct0     (funct0),
        .cond_ok    (cond_ok),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .adrsrc     (adrsrc),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .regw       (regw),
        .memw       (memw),
        .memtoreg   (memtoreg),
        .alusrc     (alusrc),
        .branch     (branch),
        .aluop      (aluop),
        .immsrc     (immsrc),
        .regsrc     (regsrc),
        .instr_done (instr_done),
        .fault      (fault)
`ifdef PERF_CNT_EN
        ,
        .cyc_cnt    (cyc_cnt),
        .instr_cnt  (instr_cnt)
`endif
    );

    // One clock cycle: drive just after the rising edge, check at the falling edge
    task automatic cyc(input logic r, input logic [1:0] o, input logic f5, input logic f0,
                       input logic c, input logic rd, input logic [15:0] e, input string nm);
        logic [15:0] ev;
        @(posedge clk);
        #1;
        rst_n = r; op = o; funct5 = f5; funct0 = f0; cond_ok = c; mem_ready = rd;
        exp_q.push_back(e);
        @(negedge clk);
        ev = exp_q.pop_front();
        n_chk++;
        if (outvec !== ev) $display("FAIL %s: got %h required %h", nm, outvec, ev);
        else n_pass++;
    endtask

    task automatic test_reset();
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, "reset_outputs0");
        cyc(1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, "reset_outputs1");
`ifdef PERF_CNT_EN
        n_chk++;
        if (cyc_cnt !== 32'd0 || instr_cnt !== 32'd0)
            $display("FAIL reset_cnt: got %0d/%0d required 0/0", cyc_cnt, instr_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_dp();
        cyc(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, V_FRDY, "add_imm_fetch");
        cyc(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, "add_imm_decode");
        cyc(1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, ASRC | AOP, "add_imm_exec");
        cyc(1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, REGW | AOP | DONE, "add_imm_wb");
        cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, V_FRDY, "add_reg_fetch");
`ifdef PERF_CNT_EN
        n_chk++;
        if (instr_cnt !== 32'd1) $display("FAIL instr_cnt_one: got %0d required 1", instr_cnt);
        else n_pass++;
`endif
        cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, "add_reg_decode");
        cyc(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, AOP, "add_reg_exec");
        cyc(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, REGW | AOP | DONE, "add_reg_wb");
    endtask

    task automatic test_load_waits();
        cyc(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, MREQ, "ldr_fetch_w1");
        cyc(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, MREQ, "ldr_fetch_w2");
        cyc(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, V_FRDY, "ldr_fetch_rdy");
        cyc(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, "ldr_decode");
        cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, ASRC | IMM01, "ldr_memadr");
        cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, MREQ | ADR, "ldr_memrd_w1");
        cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, MREQ | ADR, "ldr_memrd_w2");
        cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, MREQ | ADR, "ldr_memrd_rdy");
        cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, REGW | M2R | DONE, "ldr_memwb");
    endtask

    task automatic test_store();
        cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, V_FRDY, "str_fetch");
        cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, "str_decode");
        cyc(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, ASRC | IMM01, "str_memadr");
        cyc(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, V_WR | DONE, "str_memwr");
        cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, MREQ, "str_next_fetch");
        cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, V_FRDY, "str_next_fetch_rdy");
    endtask

    // Continues from a branch already in DECODE-ready FETCH after test_store
    task automatic test_branch();
        cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, "br1_decode");
        cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, V_BRN | PCW, "br1_branch");
        cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, V_FRDY, "br0_fetch");
        cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, "br0_decode");
        cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, V_BRN, "br0_branch");
    endtask

    task automatic test_wait_boundary();
        for (int i = 0; i < 14; i++)
            cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, MREQ, "bound_fetch_wait");
        cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, V_FRDY, "bound_ready_wins");
        cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, "bound_decode");
        cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, V_BRN, "bound_branch");
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 15; i++)
            cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, MREQ, "tmo_fetch_wait");
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, FLT, "tmo_fault_held");
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, "tmo_reset");
    endtask

    task automatic test_illegal();
        cyc(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, V_FRDY, "ill_fetch");
        cyc(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, "ill_decode");
        cyc(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, FLT, "ill_fault0");
        cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, FLT, "ill_fault1");
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, "ill_reset");
    endtask

    task automatic test_reset_mid_write();
        cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, V_FRDY, "rmw_fetch");
        cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, "rmw_decode");
        cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, ASRC | IMM01, "rmw_memadr");
        cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, V_WR, "rmw_memwr_wait");
        #2;
        rst_n = 1'b0;
        exp_q.push_back(16'h0000);
        #1;
        n_chk++;
        if (outvec !== exp_q[0]) $display("FAIL rmw_async_drop: got %h required %h", outvec, exp_q[0]);
        else n_pass++;
        void'(exp_q.pop_front());
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, "rmw_in_reset");
        cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, MREQ, "rmw_release_fetch");
`ifdef PERF_CNT_EN
        n_chk++;
        if (cyc_cnt !== 32'd0 || instr_cnt !== 32'd0)
            $display("FAIL rmw_cnt: got %0d/%0d required 0/0", cyc_cnt, instr_cnt);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_dp();
        test_load_waits();
        test_store();
        test_branch();
        test_wait_boundary();
        test_timeout();
        test_illegal();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
